wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back register file for the unpipelined single-cycle datapath.
- Consumes the result of the execute-stage units, including the 16-bit bit-reverse result, on the write port.
- Sources both operand buses for the next instruction.
- 8 x 16-bit general registers; two combinational read ports; one synchronous write port.

Parameters:
- DATA_WIDTH, 16, width of each register and of the data buses.
- NUM_REGS, 8, number of registers; must be a power of two.
- SEL_WIDTH, 3, register-select width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  datapath clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- read1RegSel  input  SEL_WIDTH  register index for read port 1.
- read2RegSel  input  SEL_WIDTH  register index for read port 2.
- writeRegSel  input  SEL_WIDTH  register index for the write port.
- writeData  input  DATA_WIDTH  write-back value (ALU/shifter/BTR/memory mux output).
- writeEn  input  1  write strobe, sampled at the rising edge of clk.
- read1Data  output  DATA_WIDTH  contents of register read1RegSel.
- read2Data  output  DATA_WIDTH  contents of register read2RegSel.
- err  output  1  registered sticky error flag.

Behaviour:
- Clock/reset:
  - One clock (clk); reset rst is synchronous and active-high.
  - rst sampled high at a rising edge clears all NUM_REGS registers to 0 and clears err to 0.
  - rst has priority over writeEn: a write presented in a reset cycle is discarded.
  - After reset, read1Data = read2Data = 0 for every select value.
- Write:
  - At the rising edge with rst=0 and writeEn=1, reg[writeRegSel] <= writeData.
  - Registers not selected are unchanged.
  - writeEn=0: no register changes, regardless of writeRegSel/writeData.
- Read:
  - Purely combinational from current register state, zero-cycle latency.
  - read1Data = reg[read1RegSel]; read2Data = reg[read2RegSel].
  - Both ports may select the same register, including the one being written.
- No hardwired-zero register: R0 is ordinary storage.
- Write/read same cycle, same index (default build):
  - Read returns the old value until the edge.
  - Read returns the new value from the edge onward: write-after-edge semantics.
- Back-to-back writes to the same register on consecutive cycles: last write wins; each is visible the cycle after its edge.
- err:
  - Set to 1 at a rising edge (rst=0) when writeEn is not a clean 0/1, or when writeEn=1 and writeRegSel contains X/Z.
  - Once set, remains 1 until rst.
  - Synthesis: the X/Z checks reduce to constant 0, so err ties low after reset.
- No internal state besides the register array and err; no multi-cycle operations; a reset mid-sequence fully restores the power-on state.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read bypass on both read ports.
  - When writeEn=1, rst=0 and readNRegSel == writeRegSel, readNData = writeData combinationally in the same cycle.
  - The register itself still updates at the edge.
  - No bypass while rst=1.
- Undefined: no bypass mux; reads always reflect stored state (default build behaviour above).

Test Plan:
- Reset then read: rst=1 for 1 cycle, sweep read1RegSel/read2RegSel over 0..7 -> both outputs 16'h0000 for every index; err=0.
- Write/readback: write R3 <= 16'hA5C3 (writeEn=1, one edge), then read1RegSel=3, read2RegSel=3 -> both 16'hA5C3; all other registers still 16'h0000.
- Bit-reverse result path: write R5 <= 16'h0001, then write R5 <= 16'h8000 on the next cycle -> read R5 shows 16'h0001 after the first edge and 16'h8000 after the second.
- Write disabled: writeEn=0, writeRegSel=2, writeData=16'hFFFF for 3 cycles -> R2 stays 16'h0000.
- Same-cycle hazard: R1 holds 16'h1234; present a write R1 <= 16'h4321 with read1RegSel=1 before the edge -> read1Data=16'h1234 without WB_REGFILE_BYPASS_EN, 16'h4321 with it; 16'h4321 after the edge in both builds.
- Reset priority: rst=1 and writeEn=1 with writeRegSel=7, writeData=16'hBEEF in the same cycle -> R7 reads 16'h0000 afterwards; the same write with rst=0 on the next cycle -> R7 reads 16'hBEEF.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back register file for the single-cycle datapath.
// NUM_REGS x DATA_WIDTH storage, two combinational read ports, one
// synchronous write port, sticky err flag for X/Z on the write controls.
// Optional macro WB_REGFILE_BYPASS_EN adds a same-cycle write-to-read
// bypass on both read ports; undefined, reads show stored state only.

// One storage register; reset has priority over the write strobe.
module wb_regfile_cell #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic [DATA_WIDTH-1:0] r_q;

    // Clear on reset, otherwise capture write data when strobed.
    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else if (i_we)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

module wb_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,   // power of two
    parameter int SEL_WIDTH  = 3    // log2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_WIDTH-1:0]  read1RegSel,
    input  logic [SEL_WIDTH-1:0]  read2RegSel,
    input  logic [SEL_WIDTH-1:0]  writeRegSel,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  writeEn,
    output logic [DATA_WIDTH-1:0] read1Data,
    output logic [DATA_WIDTH-1:0] read2Data,
    output logic                  err
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_regs;
    logic [NUM_REGS-1:0]                 w_cell_we;
    logic                                w_err_evt;
    logic                                r_err;

    // Per-register write enable from the decoded write select, plus storage.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign w_cell_we[g] = writeEn && (writeRegSel == SEL_WIDTH'(g));

        wb_regfile_cell #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .i_we (w_cell_we[g]),
            .i_d  (writeData),
            .o_q  (w_regs[g])
        );
    end

`ifdef WB_REGFILE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    // Forward the in-flight write to any port reading the same index.
    assign w_byp1    = writeEn && !rst && (read1RegSel == writeRegSel);
    assign w_byp2    = writeEn && !rst && (read2RegSel == writeRegSel);
    assign read1Data = w_byp1 ? writeData : w_regs[read1RegSel];
    assign read2Data = w_byp2 ? writeData : w_regs[read2RegSel];
`else
    // Reads reflect stored state only; a write is visible after its edge.
    assign read1Data = w_regs[read1RegSel];
    assign read2Data = w_regs[read2RegSel];
`endif

    // X/Z on the write controls is only observable in 4-state simulation;
    // hardware sees clean levels, so the event is constant 0 there.
`ifndef SYNTHESIS
    assign w_err_evt = $isunknown(writeEn) ||
                       ((writeEn === 1'b1) && $isunknown(writeRegSel));
`else
    assign w_err_evt = 1'b0;
`endif

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_err_evt)
            r_err <= 1'b1;
    end

    assign err = r_err;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (honours WB_REGFILE_BYPASS_EN).
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [2:0]  read1RegSel;
    logic [2:0]  read2RegSel;
    logic [2:0]  writeRegSel;
    logic [15:0] writeData;
    logic        writeEn;
    logic [15:0] read1Data;
    logic [15:0] read2Data;
    logic        err;

    int total = 0;
    int bad   = 0;

    wb_regfile #(
        .DATA_WIDTH (16),
        .NUM_REGS   (8),
        .SEL_WIDTH  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .read1RegSel (read1RegSel),
        .read2RegSel (read2RegSel),
        .writeRegSel (writeRegSel),
        .writeData   (writeData),
        .writeEn     (writeEn),
        .read1Data   (read1Data),
        .read2Data   (read2Data),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One write cycle: set up on the falling edge, strobe low again just after the rising edge.
    task automatic do_write(input logic [2:0] sel, input logic [15:0] data);
        @(negedge clk);
        writeEn     = 1'b1;
        writeRegSel = sel;
        writeData   = data;
        @(posedge clk);
        #1;
        writeEn = 1'b0;
    endtask

    task automatic rd(input logic [2:0] s1, input logic [2:0] s2);
        read1RegSel = s1;
        read2RegSel = s2;
        #1;
    endtask

    logic [15:0] exp_hazard;

    initial begin
        rst = 1'b1; writeEn = 1'b0; writeRegSel = '0; writeData = '0;
        read1RegSel = '0; read2RegSel = '0;

        // Reset for one cycle, then sweep every index on both ports.
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(7 - i));
            chk($sformatf("rst_rd1_%0d", i), {16'h0, read1Data}, 32'h0);
            chk($sformatf("rst_rd2_%0d", 7 - i), {16'h0, read2Data}, 32'h0);
        end
        chk("rst_err", {31'h0, err}, 32'h0);

        // Basic write/readback; others untouched.
        do_write(3'd3, 16'hA5C3);
        rd(3'd3, 3'd3);
        chk("wr_r3_p1", {16'h0, read1Data}, 32'h0000A5C3);
        chk("wr_r3_p2", {16'h0, read2Data}, 32'h0000A5C3);
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                rd(3'(i), 3'(i));
                chk($sformatf("wr_other_%0d", i), {16'h0, read1Data}, 32'h0);
            end
        end

        // Back-to-back writes to R5.
        rd(3'd5, 3'd5);
        @(negedge clk);
        writeEn = 1'b1; writeRegSel = 3'd5; writeData = 16'h0001;
        @(posedge clk); #1;
        chk("b2b_first", {16'h0, read1Data}, 32'h00000001);
        writeData = 16'h8000;
        @(posedge clk); #1;
        writeEn = 1'b0;
        chk("b2b_second", {16'h0, read2Data}, 32'h00008000);

        // Write disabled for three cycles.
        @(negedge clk);
        writeEn = 1'b0; writeRegSel = 3'd2; writeData = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        rd(3'd2, 3'd2);
        chk("wen0_r2", {16'h0, read1Data}, 32'h0);

        // R0 is ordinary storage.
        do_write(3'd0, 16'h5A5A);
        rd(3'd0, 3'd5);
        chk("r0_store", {16'h0, read1Data}, 32'h00005A5A);
        chk("r5_keep", {16'h0, read2Data}, 32'h00008000);

        // Same-cycle write/read hazard on R1.
        do_write(3'd1, 16'h1234);
        @(negedge clk);
        read1RegSel = 3'd1; read2RegSel = 3'd3;
        writeEn = 1'b1; writeRegSel = 3'd1; writeData = 16'h4321;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        exp_hazard = 16'h4321;
`else
        exp_hazard = 16'h1234;
`endif
        chk("haz_pre", {16'h0, read1Data}, {16'h0, exp_hazard});
        chk("haz_p2_other", {16'h0, read2Data}, 32'h0000A5C3);
        @(posedge clk); #1;
        writeEn = 1'b0;
        chk("haz_post", {16'h0, read1Data}, 32'h00004321);

        // Reset priority over a write; full state restored.
        @(negedge clk);
        rst = 1'b1; writeEn = 1'b1; writeRegSel = 3'd7; writeData = 16'hBEEF;
        @(posedge clk); #1;
        rst = 1'b0; writeEn = 1'b0;
        rd(3'd7, 3'd3);
        chk("rstpri_r7", {16'h0, read1Data}, 32'h0);
        chk("rstpri_r3", {16'h0, read2Data}, 32'h0);
        rd(3'd1, 3'd5);
        chk("rstpri_r1", {16'h0, read1Data}, 32'h0);
        chk("rstpri_r5", {16'h0, read2Data}, 32'h0);
        do_write(3'd7, 16'hBEEF);
        rd(3'd7, 3'd7);
        chk("post_rst_r7", {16'h0, read2Data}, 32'h0000BEEF);
        chk("end_err", {31'h0, err}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
